conv_tile_output_serializer: RTL

- Downstream neighbour of the convolution top (input control unit + PE).
- Captures each parallel output tile of (INPUT_TILE_SIZE-KERNEL_SIZE+1)^2 signed accumulator words when the PE flags it valid.
- Buffers up to two tiles, requantizes each word to OUT_WIDTH bits (round, optional ReLU, saturate), and streams the words out one per cycle over a valid/ready handshake, marking the tile's last word.

---
 rtl/conv_out_pkg.sv | 29 ++
 rtl/requant_sat.sv | 37 +++
 rtl/conv_tile_output_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/conv_out_pkg.sv
// Shared sizing helpers, default-derived sizes and FSM encoding for the tile serializer.
package conv_out_pkg;

  localparam int unsigned DEF_KERNEL_SIZE       = 3;
  localparam int unsigned DEF_INPUT_TILE_SIZE   = 4;
  localparam int unsigned DEF_INPUT_DATA_WIDTH  = 8;
  localparam int unsigned DEF_KERNEL_DATA_WIDTH = 8;

  // Output tile edge of a valid (no padding) convolution.
  function automatic int unsigned calc_p_out(int unsigned tile_size, int unsigned kernel_size);
    return tile_size - kernel_size + 1;
  endfunction

  // Accumulator width: product width plus headroom for the kernel sum.
  function automatic int unsigned calc_acc_width(int unsigned kdw, int unsigned idw);
    return kdw + idw + 13;
  endfunction

  localparam int unsigned P_OUT     = calc_p_out(DEF_INPUT_TILE_SIZE, DEF_KERNEL_SIZE);
  localparam int unsigned ACC_WIDTH = calc_acc_width(DEF_KERNEL_DATA_WIDTH, DEF_INPUT_DATA_WIDTH);
  localparam int unsigned N_WORDS   = P_OUT * P_OUT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/requant_sat.sv
// Round-half-up arithmetic right shift followed by ReLU/unsigned or signed saturation.
module requant_sat #(
  parameter int unsigned ACC_WIDTH = 29,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SHIFT     = 8,
  parameter int unsigned RELU      = 1
) (
  input  logic signed [ACC_WIDTH-1:0] x_i,
  output logic        [OUT_WIDTH-1:0] y_o
);

  // One guard bit so the rounding add can never wrap.
  localparam int unsigned EW     = ACC_WIDTH + 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EW-1:0] RND  = (SHIFT > 0) ? (EW'(1) << RND_SH) : '0;
  localparam logic signed [EW-1:0] MAX_U = $signed((EW'(1) << OUT_WIDTH) - EW'(1));
  localparam logic signed [EW-1:0] MAX_S = $signed((EW'(1) << (OUT_WIDTH - 1)) - EW'(1));
  localparam logic signed [EW-1:0] MIN_S = ~MAX_S;

  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] y;

  // Round, shift, then clamp into the output range.
  always_comb begin
    sum = $signed({x_i[ACC_WIDTH-1], x_i}) + $signed(RND);
    y   = sum >>> SHIFT;
    y_o = y[OUT_WIDTH-1:0];
    if (RELU != 0) begin
      if (y[EW-1])       y_o = '0;
      else if (y > MAX_U) y_o = MAX_U[OUT_WIDTH-1:0];
    end else begin
      if (y > MAX_S)      y_o = MAX_S[OUT_WIDTH-1:0];
      else if (y < MIN_S) y_o = MIN_S[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv_tile_output_serializer.sv
// Captures PE output tiles into a 2-deep tile FIFO and streams requantized words over valid/ready.
module conv_tile_output_serializer
  import conv_out_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE       = 3,
  parameter int unsigned INPUT_TILE_SIZE   = 4,
  parameter int unsigned INPUT_DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH         = 8,
  parameter int unsigned SHIFT             = 8,
  parameter int unsigned RELU              = 1,
  localparam int unsigned P      = calc_p_out(INPUT_TILE_SIZE, KERNEL_SIZE),
  localparam int unsigned ACC    = calc_acc_width(KERNEL_DATA_WIDTH, INPUT_DATA_WIDTH),
  localparam int unsigned TILE_W = P * P * ACC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TILE_W-1:0]    i_tile_data,
  input  logic                 i_tile_valid,
  output logic                 o_tile_ready,
  output logic [OUT_WIDTH-1:0] o_pixel_data,
  output logic                 o_pixel_valid,
  output logic                 o_pixel_last,
  input  logic                 i_pixel_ready,
  output logic                 o_tile_done,
  output logic                 o_drop
);

  localparam int unsigned N     = P * P;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [TILE_W-1:0]    buf_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;
  state_e               state_q, state_d;
  logic [TILE_W-1:0]    sreg_q, sreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 drop_q;
  logic [OUT_WIDTH-1:0] data_q, rq_word;
  logic                 pop_c, push_c, hs_c;

  assign hs_c         = valid_q & i_pixel_ready;
  assign o_tile_ready = (count_q < 2'd2) | pop_c;
  assign push_c       = i_tile_valid & o_tile_ready;

  // Next state, shift-register advance and pop decision; a pop reloads word 0 with no bubble.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != 2'd0) pop_c = 1'b1;
      end
      ST_LOAD, ST_EMIT: begin
        state_d = ST_EMIT;
        if (hs_c) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            valid_d = 1'b0;
            state_d = ST_IDLE;
            if (count_q != 2'd0) pop_c = 1'b1;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            sreg_d = sreg_q >> ACC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop_c) begin
      state_d = ST_LOAD;
      sreg_d  = buf_q[rd_ptr_q];
      idx_d   = '0;
      valid_d = 1'b1;
    end
    last_d = valid_d & (idx_d == LAST_IDX);
  end

  requant_sat #(
    .ACC_WIDTH(ACC),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT),
    .RELU     (RELU)
  ) u_requant (
    .x_i(sreg_d[ACC-1:0]),
    .y_o(rq_word)
  );

  // Tile storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_c) buf_q[wr_ptr_q] <= i_tile_data;
  end

  // Control, pointers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sreg_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      data_q  <= rq_word;
      count_q <= count_q + {1'b0, push_c} - {1'b0, pop_c};
      if (push_c) wr_ptr_q <= ~wr_ptr_q;
      if (pop_c)  rd_ptr_q <= ~rd_ptr_q;
      if (i_tile_valid && !o_tile_ready) drop_q <= 1'b1;
    end
  end

  assign o_pixel_data  = data_q;
  assign o_pixel_valid = valid_q;
  assign o_pixel_last  = last_q;
  assign o_tile_done   = done_q;
  assign o_drop        = drop_q;

endmodule
